// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the 7-segment display arbiter.
// State encoding is fixed so waveforms read the same across tools.
package seg_disp_pkg;

    localparam int DISP_W = 16;
    localparam logic [DISP_W-1:0] IDLE_VALUE_DEF = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_PIN  = 2'd2
    } state_e;

endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// Round-robin search: first set request after `last`, wrapping,
// with `last` itself examined at the very end.
module rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
)(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    int                 j;
    logic [SEL_W-1:0]   jj;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        jj    = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            j  = (int'(last) + k) % NUM_SRC;
            jj = SEL_W'(j);
            if (!found && req[jj]) begin
                found = 1'b1;
                idx   = jj;
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares one 4-digit hex display among several requesters with
// round-robin ownership, a minimum hold time and a debug pin override.
module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter int                NUM_SRC     = 4,
    parameter int                CNT_W       = 24,
    parameter logic [CNT_W-1:0]  HOLD_CYCLES = 24'd2_500_000,
    parameter logic [DISP_W-1:0] IDLE_VALUE  = IDLE_VALUE_DEF,
    localparam int               SEL_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_req,
    input  logic [DISP_W*NUM_SRC-1:0] src_data,
    input  logic                      pin_en,
    input  logic [SEL_W-1:0]          pin_sel,
    output logic [DISP_W-1:0]         disp_data,
    output logic [NUM_SRC-1:0]        grant,
    output logic [SEL_W-1:0]          owner,
    output logic                      owner_valid,
    output logic                      switch_pulse
);

    localparam logic [CNT_W-1:0] RELOAD = HOLD_CYCLES - CNT_W'(1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SEL_W-1:0]    owner_q, owner_d;
    logic                valid_q, valid_d;
    logic [NUM_SRC-1:0]  grant_q, grant_d;
    logic                pulse_q, pulse_d;
    logic [DISP_W-1:0]   disp_q, disp_d;

    logic                pick_found;
    logic [SEL_W-1:0]    pick_idx;
    logic                owner_ok;
    logic                owner_req;
    logic                pin_ok;
    logic [DISP_W-1:0]   src_word [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_word
        assign src_word[g] = src_data[DISP_W*g +: DISP_W];
    end

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_pick (
        .req   (src_req),
        .last  (owner_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign owner_ok  = (int'(owner_q) < NUM_SRC);
    assign owner_req = owner_ok && src_req[owner_q];
    assign pin_ok    = (int'(pin_sel) < NUM_SRC);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        valid_d = valid_q;
        if (pin_en) begin
            state_d = ST_PIN;
            owner_d = pin_sel;
            valid_d = pin_ok;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        state_d = ST_HOLD;
                        owner_d = pick_idx;
                        valid_d = 1'b1;
                        cnt_d   = RELOAD;
                    end
                end
                ST_HOLD: begin
                    if (!owner_req) begin
                        // Owner gave up the display: skip the remaining hold.
                        if (pick_found) begin
                            owner_d = pick_idx;
                            cnt_d   = RELOAD;
                        end else begin
                            state_d = ST_IDLE;
                            valid_d = 1'b0;
                        end
                    end else if (cnt_q == '0) begin
                        if (pick_idx != owner_q) begin
                            owner_d = pick_idx;
                            cnt_d   = RELOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_PIN: begin
                    state_d = ST_HOLD;
                    valid_d = 1'b1;
                    cnt_d   = RELOAD;
                    if (owner_req) begin
                        owner_d = owner_q;
                    end else if (pick_found) begin
                        owner_d = pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        cnt_d   = cnt_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        grant_d = '0;
        if (valid_d) begin
            grant_d[owner_d] = 1'b1;
        end
        pulse_d = (valid_d != valid_q) || (owner_d != owner_q);
        disp_d  = (valid_q && owner_ok) ? src_word[owner_q] : IDLE_VALUE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            owner_q <= SEL_W'(NUM_SRC - 1);
            valid_q <= 1'b0;
            grant_q <= '0;
            pulse_q <= 1'b0;
            disp_q  <= IDLE_VALUE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            valid_q <= valid_d;
            grant_q <= grant_d;
            pulse_q <= pulse_d;
            disp_q  <= disp_d;
        end
    end

    assign disp_data    = disp_q;
    assign grant        = grant_q;
    assign owner        = owner_q;
    assign owner_valid  = valid_q;
    assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter (4 sources, hold of 4).
module tb_seg_display_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src_req;
    logic [63:0] src_data;
    logic        pin_en;
    logic [1:0]  pin_sel;
    logic [15:0] disp_data;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        owner_valid;
    logic        switch_pulse;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_display_arbiter #(
        .NUM_SRC     (4),
        .CNT_W       (8),
        .HOLD_CYCLES (8'd4),
        .IDLE_VALUE  (16'h0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src_req      (src_req),
        .src_data     (src_data),
        .pin_en       (pin_en),
        .pin_sel      (pin_sel),
        .disp_data    (disp_data),
        .grant        (grant),
        .owner        (owner),
        .owner_valid  (owner_valid),
        .switch_pulse (switch_pulse)
    );

    typedef struct {
        logic [3:0]  req;
        logic        pe;
        logic [1:0]  ps;
        logic [23:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [23:0] E(logic [3:0] g, logic [1:0] o,
                                      logic v, logic p, logic [15:0] d);
        return {g, o, v, p, d};
    endfunction

    function automatic vec_t V(logic [3:0] req, logic pe, logic [1:0] ps,
                               logic [23:0] exp);
        vec_t t;
        t.req = req;
        t.pe  = pe;
        t.ps  = ps;
        t.exp = exp;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [23:0] exp);
        logic [23:0] act;
        act = {grant, owner, owner_valid, switch_pulse, disp_data};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got g/o/v/p/disp=%b/%0d/%b/%b/%h want %b/%0d/%b/%b/%h",
                     nm, act[23:20], act[19:18], act[17], act[16], act[15:0],
                     exp[23:20], exp[19:18], exp[17], exp[16], exp[15:0]);
        end
    endtask

    // Reference model: plain integer bookkeeping of who owns the display.
    int          m_mode;
    int          m_owner;
    int          m_left;
    bit          m_valid;
    bit          m_pulse;
    logic [15:0] m_disp;

    function automatic int rr(int from, logic [3:0] req);
        for (int k = 1; k <= 4; k++) begin
            if (req[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic m_start(int p);
        m_mode  = 1;
        m_owner = p;
        m_valid = 1;
        m_left  = 3;
    endtask

    task automatic m_idle();
        m_mode  = 0;
        m_valid = 0;
    endtask

    task automatic model(input logic r, input logic [3:0] req, input logic pe,
                         input logic [1:0] ps, input logic [63:0] data);
        int          po;
        bit          pv;
        int          p;
        logic [15:0] nd;
        po = m_owner;
        pv = m_valid;
        nd = m_valid ? data[16*m_owner +: 16] : 16'h0000;
        if (r) begin
            m_mode  = 0;
            m_owner = 3;
            m_valid = 0;
            m_left  = 0;
            m_disp  = 16'h0000;
            m_pulse = 0;
            return;
        end
        m_disp = nd;
        p = rr(m_owner, req);
        if (pe) begin
            m_mode  = 2;
            m_owner = int'(ps);
            m_valid = 1;
        end else if (m_mode == 0) begin
            if (p >= 0) m_start(p);
        end else if (m_mode == 1) begin
            if (!req[m_owner]) begin
                if (p >= 0) m_start(p);
                else m_idle();
            end else if (m_left == 0) begin
                if (p != m_owner) m_start(p);
            end else begin
                m_left = m_left - 1;
            end
        end else begin
            if (req[m_owner]) m_start(m_owner);
            else if (p >= 0) m_start(p);
            else m_idle();
        end
        m_pulse = (m_owner != po) || (m_valid != pv);
    endtask

    function automatic logic [23:0] m_exp();
        logic [3:0] g;
        g = m_valid ? 4'(1 << m_owner) : 4'b0000;
        return {g, 2'(m_owner), m_valid, m_pulse, m_disp};
    endfunction

    initial begin
        rst      = 1'b1;
        src_req  = '0;
        pin_en   = 1'b0;
        pin_sel  = '0;
        src_data = {16'hA0A3, 16'hA0A2, 16'hA0A1, 16'hA0A0};
        step();
        step();
        check("reset", E(4'b0000, 2'd3, 0, 0, 16'h0000));
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle", E(4'b0000, 2'd3, 0, 0, 16'h0000));
        end

        tbl.push_back(V(4'b1011, 0, 0, E(4'b0001, 0, 1, 1, 16'h0000)));
        for (int i = 0; i < 3; i++)
            tbl.push_back(V(4'b1011, 0, 0, E(4'b0001, 0, 1, 0, 16'hA0A0)));
        tbl.push_back(V(4'b1011, 0, 0, E(4'b0010, 1, 1, 1, 16'hA0A0)));
        for (int i = 0; i < 3; i++)
            tbl.push_back(V(4'b1011, 0, 0, E(4'b0010, 1, 1, 0, 16'hA0A1)));
        tbl.push_back(V(4'b1011, 0, 0, E(4'b1000, 3, 1, 1, 16'hA0A1)));
        for (int i = 0; i < 3; i++)
            tbl.push_back(V(4'b1011, 0, 0, E(4'b1000, 3, 1, 0, 16'hA0A3)));
        tbl.push_back(V(4'b1011, 0, 0, E(4'b0001, 0, 1, 1, 16'hA0A3)));
        for (int i = 0; i < 3; i++)
            tbl.push_back(V(4'b1011, 0, 0, E(4'b0001, 0, 1, 0, 16'hA0A0)));
        tbl.push_back(V(4'b1011, 0, 0, E(4'b0010, 1, 1, 1, 16'hA0A0)));
        tbl.push_back(V(4'b1011, 0, 0, E(4'b0010, 1, 1, 0, 16'hA0A1)));
        tbl.push_back(V(4'b1001, 0, 0, E(4'b1000, 3, 1, 1, 16'hA0A1)));
        tbl.push_back(V(4'b0000, 0, 0, E(4'b0000, 3, 0, 1, 16'hA0A3)));
        tbl.push_back(V(4'b0000, 0, 0, E(4'b0000, 3, 0, 0, 16'h0000)));
        tbl.push_back(V(4'b0000, 1, 2, E(4'b0100, 2, 1, 1, 16'h0000)));
        tbl.push_back(V(4'b0000, 1, 2, E(4'b0100, 2, 1, 0, 16'hA0A2)));
        tbl.push_back(V(4'b0000, 1, 1, E(4'b0010, 1, 1, 1, 16'hA0A2)));
        tbl.push_back(V(4'b0000, 0, 0, E(4'b0000, 1, 0, 1, 16'hA0A1)));
        tbl.push_back(V(4'b0000, 0, 0, E(4'b0000, 1, 0, 0, 16'h0000)));

        foreach (tbl[i]) begin
            src_req = tbl[i].req;
            pin_en  = tbl[i].pe;
            pin_sel = tbl[i].ps;
            step();
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        src_data[15:0] = 16'hBEEF;
        src_req = 4'b0001;
        step();
        check("beef_grant", E(4'b0001, 0, 1, 1, 16'h0000));
        step();
        check("beef_data", E(4'b0001, 0, 1, 0, 16'hBEEF));

        src_req = 4'b1111;
        step();
        step();
        check("hold_mid", E(4'b0001, 0, 1, 0, 16'hBEEF));
        rst = 1'b1;
        step();
        check("rst_mid", E(4'b0000, 3, 0, 0, 16'h0000));
        rst = 1'b0;
        step();
        check("after_rst", E(4'b0001, 0, 1, 1, 16'h0000));

        src_req = 4'b0000;
        src_data[47:32] = 16'h1234;
        pin_en  = 1'b1;
        pin_sel = 2'd2;
        step();
        check("pin_grant", E(4'b0100, 2, 1, 1, 16'hBEEF));
        step();
        check("pin_data", E(4'b0100, 2, 1, 0, 16'h1234));
        pin_en = 1'b0;
        step();
        check("unpin_idle", E(4'b0000, 2, 0, 1, 16'h1234));

        rst = 1'b1;
        model(1'b1, src_req, pin_en, pin_sel, src_data);
        step();
        check("rand_rst", m_exp());
        rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 3) == 0) src_req = 4'($urandom);
            if ($urandom_range(0, 11) == 0) pin_en = ~pin_en;
            if ($urandom_range(0, 5) == 0) pin_sel = 2'($urandom);
            src_data = {$urandom, $urandom};
            model(rst, src_req, pin_en, pin_sel, src_data);
            step();
            check($sformatf("rand%0d", i), m_exp());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
